ring_buf_wr_arb: RTL and testbench

- Write-side scheduler for a multi-lane ring buffer: REQ requesters share its WRITE write lanes.
- Each cycle, at most one requester is granted, chosen round-robin among those whose whole burst fits the free space.
- Tracks buffer occupancy internally from granted writes and a consumer pop count, so the buffer never overflows.
- Sits between producer agents and the ring buffer's we/wd ports.

---
 rtl/ring_buf_wr_arb.sv | 192 +++++++++++++++++++
 tb/tb_ring_buf_wr_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_buf_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : ring_buf_wr_arb
// Purpose  : Write-side scheduler for a multi-lane ring buffer. Up to one
//            requester is granted per cycle. The winner is picked round-robin
//            among the requesters whose whole burst fits the free space. The
//            block keeps its own occupancy count from granted writes and the
//            consumer pop count, so the buffer cannot overflow.
// Ports    : clk, reset (async, active-high), flush_ (sync, active-low)
//            req/req_cnt/req_wd : per-requester burst request
//            pop_cnt            : entries consumed from the buffer this cycle
//            gnt                : one-hot grant, same cycle as the request
//            we/wd              : buffer write lanes (we polarity set by ACT)
//            free               : free entries, from the occupancy register
//            err                : sticky protocol-error flag
// Options  : define RING_BUF_WR_ARB_AGE_EN to add per-requester age counters
//            that stop large bursts from starving.
// Revision : 1.0 - initial release
// ============================================================================
module ring_buf_wr_arb #(
    parameter int DATA    = 32,
    parameter int DEPTH   = 24,
    parameter int WRITE   = 4,
    parameter int REQ     = 4,
    parameter int ACT     = 1,
    parameter int MAXWAIT = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush_,
    input  logic [REQ-1:0]                      req,
    input  logic [REQ*($clog2(WRITE)+1)-1:0]    req_cnt,
    input  logic [REQ*WRITE*DATA-1:0]           req_wd,
    input  logic [$clog2(DEPTH+1)-1:0]          pop_cnt,
    output logic [REQ-1:0]                      gnt,
    output logic [WRITE-1:0]                    we,
    output logic [WRITE*DATA-1:0]               wd,
    output logic [$clog2(DEPTH+1)-1:0]          free,
    output logic                                err
);

    localparam int c_cw = $clog2(WRITE) + 1;
    localparam int c_fw = $clog2(DEPTH + 1);
    localparam int c_pw = (REQ > 1) ? $clog2(REQ) : 1;

    logic [c_fw-1:0]       occ_q, occ_d;
    logic [c_pw-1:0]       rr_q, rr_d;
    logic                  err_q, err_d;

    logic [c_fw-1:0]       w_free;
    logic [c_cw-1:0]       w_cnt [REQ];
    logic [REQ-1:0]        w_illegal;
    logic [REQ-1:0]        w_elig;
    logic [REQ-1:0]        w_mask;
    logic                  w_found;
    logic [c_pw-1:0]       w_win;
    logic [REQ-1:0]        w_gnt;
    logic [c_cw-1:0]       w_gcnt;
    logic [WRITE-1:0]      w_we_act;
    logic [WRITE*DATA-1:0] w_wd;
    logic [c_fw:0]         w_sum;

    assign w_free = c_fw'(DEPTH) - occ_q;

    // Eligibility uses the registered free count only; pops this cycle
    // make room from the next cycle on.
    always_comb begin
        for (int i = 0; i < REQ; i++) begin
            w_cnt[i]     = req_cnt[i*c_cw +: c_cw];
            w_illegal[i] = req[i] && ((w_cnt[i] == '0) || (int'(w_cnt[i]) > WRITE));
            w_elig[i]    = req[i] && !w_illegal[i] && (int'(w_cnt[i]) <= int'(w_free));
        end
    end

`ifdef RING_BUF_WR_ARB_AGE_EN
    localparam int c_aw = $clog2(MAXWAIT + 1);

    logic [c_aw-1:0] age_q [REQ];
    logic [c_aw-1:0] age_d [REQ];
    logic            w_aged_found;

    // The lowest-index requester that has waited MAXWAIT cycles locks
    // out everyone else until it fits and is served.
    always_comb begin
        w_mask       = '1;
        w_aged_found = 1'b0;
        for (int i = 0; i < REQ; i++) begin
            if (!w_aged_found && (int'(age_q[i]) >= MAXWAIT)) begin
                w_mask       = '0;
                w_mask[i]    = 1'b1;
                w_aged_found = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < REQ; i++) begin
            if (!req[i] || w_gnt[i]) begin
                age_d[i] = '0;
            end else if (int'(age_q[i]) < MAXWAIT) begin
                age_d[i] = age_q[i] + c_aw'(1);
            end else begin
                age_d[i] = age_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REQ; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REQ; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end
`else
    assign w_mask = '1;
`endif

    // Round-robin search starting at rr_q, with wrap-around. Reset and flush
    // suppress grants combinationally, so gnt/we drop at once.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < REQ; k++) begin
            idx = (int'(rr_q) + k) % REQ;
            if (!w_found && w_elig[idx] && w_mask[idx] && flush_ && !reset) begin
                w_found = 1'b1;
                w_win   = c_pw'(idx);
            end
        end
    end

    always_comb begin
        w_gnt  = '0;
        w_gcnt = '0;
        w_wd   = '0;
        if (w_found) begin
            w_gnt[w_win] = 1'b1;
            w_gcnt       = w_cnt[w_win];
            w_wd         = req_wd[int'(w_win)*WRITE*DATA +: WRITE*DATA];
        end
        for (int j = 0; j < WRITE; j++) begin
            w_we_act[j] = (j < int'(w_gcnt));
        end
    end

    assign gnt  = w_gnt;
    assign we   = (ACT != 0) ? w_we_act : ~w_we_act;
    assign wd   = w_wd;
    assign free = w_free;
    assign err  = err_q;

    // Occupancy: the granted burst and the pop are both applied. A pop larger
    // than the available entries clamps to empty and flags an error.
    always_comb begin
        w_sum = {1'b0, occ_q} + (c_fw+1)'(w_gcnt);
        occ_d = occ_q;
        rr_d  = rr_q;
        err_d = err_q | (|w_illegal);
        if (!flush_) begin
            occ_d = '0;
        end else if ({1'b0, pop_cnt} > w_sum) begin
            occ_d = '0;
            err_d = 1'b1;
        end else begin
            occ_d = c_fw'(w_sum - {1'b0, pop_cnt});
        end
        if (w_found) begin
            rr_d = (int'(w_win) == REQ - 1) ? '0 : w_win + c_pw'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ring_buf_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_buf_wr_arb
// Purpose  : Directed self-checking bench for ring_buf_wr_arb (default
//            parameters, MAXWAIT=4 for the optional aging scenario).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_buf_wr_arb;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush_;
    logic [3:0]   req;
    logic [11:0]  req_cnt;
    logic [511:0] req_wd;
    logic [4:0]   pop_cnt;
    logic [3:0]   gnt;
    logic [3:0]   we;
    logic [127:0] wd;
    logic [4:0]   free;
    logic         err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ring_buf_wr_arb #(.MAXWAIT(4)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .flush_  (flush_),
        .req     (req),
        .req_cnt (req_cnt),
        .req_wd  (req_wd),
        .pop_cnt (pop_cnt),
        .gnt     (gnt),
        .we      (we),
        .wd      (wd),
        .free    (free),
        .err     (err)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_all();
        req     = '0;
        req_cnt = '0;
        req_wd  = '0;
    endtask

    // Lanes below cnt carry base+lane, upper lanes are zero.
    task automatic set_req(input int i, input int cnt, input int base);
        logic [2:0] c;
        c = 3'(cnt);
        req[i]            = 1'b1;
        req_cnt[i*3 +: 3] = c;
        for (int j = 0; j < 4; j++) begin
            req_wd[(i*4+j)*32 +: 32] = (j < cnt) ? 32'(base + j) : 32'd0;
        end
    endtask

    task automatic do_reset();
        clr_all();
        pop_cnt = '0;
        flush_  = 1'b1;
        reset   = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Single granted burst from requester idx; the requester drops after the edge.
    task automatic fill(input int idx, input int cnt);
        clr_all();
        set_req(idx, cnt, 0);
        #1;
        chk("fill_gnt", gnt, 128'(4'b0001 << idx));
        step();
        clr_all();
    endtask

    initial begin
        reset   = 1'b1;
        flush_  = 1'b1;
        pop_cnt = '0;
        clr_all();
        step();
        step();

        // 1: reset state, then zero-latency grant
        set_req(0, 2, 1);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_we", we, 0);
        chk("rst_wd", wd, 0);
        chk("rst_free", free, 24);
        reset = 1'b0;
        #1;
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_we", we, 4'b0011);
        chk("t1_wd", wd, {32'd0, 32'd0, 32'd2, 32'd1});
        step();
        clr_all();
        #1;
        chk("t1_free", free, 22);

        // 2: four full bursts, strict round-robin order
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 4, 16 * i);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_gnt", gnt, 128'(4'b0001 << k));
            chk("t2_we", we, 4'b1111);
            chk("t2_free", free, 128'(24 - 4 * k));
            if (k == 2) chk("t2_wd", wd, {32'd35, 32'd34, 32'd33, 32'd32});
            step();
            req[k] = 1'b0;
        end
        #1;
        chk("t2_free_end", free, 8);

        // 3: small burst bypasses a large one; pop makes room next cycle
        fill(0, 4);
        fill(1, 2);
        set_req(1, 4, 100);
        set_req(2, 1, 200);
        pop_cnt = 5'd3;
        #1;
        chk("t3_bypass_gnt", gnt, 4'b0100);
        chk("t3_bypass_we", we, 4'b0001);
        chk("t3_bypass_wd", wd, 128'd200);
        step();
        req[2]  = 1'b0;
        pop_cnt = '0;
        #1;
        chk("t3_free", free, 4);
        chk("t3_big_gnt", gnt, 4'b0010);
        step();
        clr_all();
        set_req(0, 1, 7);
        #1;
        chk("t3_full_free", free, 0);
        chk("t3_full_gnt", gnt, 0);
        clr_all();

        // 4: grant and pop together, then underflow
        do_reset();
        fill(0, 4);
        fill(1, 4);
        fill(2, 2);
        set_req(3, 3, 50);
        pop_cnt = 5'd2;
        #1;
        chk("t4_gnt", gnt, 4'b1000);
        step();
        clr_all();
        pop_cnt = '0;
        #1;
        chk("t4_free", free, 13);
        pop_cnt = 5'd11;
        step();
        pop_cnt = '0;
        #1;
        chk("t4_empty_free", free, 24);
        chk("t4_err_clean", err, 0);
        pop_cnt = 5'd5;
        step();
        pop_cnt = '0;
        #1;
        chk("t4_uflow_free", free, 24);
        chk("t4_uflow_err", err, 1);
        step();
        chk("t4_err_sticky", err, 1);

        // illegal burst lengths: never granted, set err
        do_reset();
        #1;
        chk("ill_err_rst", err, 0);
        set_req(0, 0, 0);
        set_req(1, 5, 0);
        #1;
        chk("ill_gnt", gnt, 0);
        step();
        clr_all();
        #1;
        chk("ill_err", err, 1);

        // 5: flush with pending requests, rr pointer retained, reset mid-grant
        do_reset();
        fill(0, 4);
        fill(1, 4);
        fill(2, 4);
        fill(3, 4);
        fill(0, 4);
        set_req(0, 1, 60);
        set_req(2, 1, 70);
        flush_  = 1'b0;
        pop_cnt = 5'd7;
        #1;
        chk("t5_fl_gnt", gnt, 0);
        chk("t5_fl_we", we, 0);
        step();
        flush_  = 1'b1;
        pop_cnt = '0;
        #1;
        chk("t5_free", free, 24);
        chk("t5_err", err, 0);
        chk("t5_rr_gnt", gnt, 4'b0100);
        reset = 1'b1;
        #1;
        chk("t5_rst_gnt", gnt, 0);
        chk("t5_rst_we", we, 0);
        chk("t5_rst_wd", wd, 0);
        chk("t5_rst_free", free, 24);
        step();
        reset = 1'b0;
        clr_all();

`ifdef RING_BUF_WR_ARB_AGE_EN
        // 6: aged large burst blocks small traffic until it fits
        do_reset();
        fill(0, 4);
        fill(1, 4);
        fill(2, 4);
        fill(3, 4);
        fill(0, 4);
        fill(1, 2);
        set_req(0, 4, 80);
        set_req(1, 1, 90);
        pop_cnt = 5'd1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t6_small_gnt", gnt, 4'b0010);
            step();
        end
        pop_cnt = 5'd2;
        #1;
        chk("t6_block_gnt", gnt, 0);
        step();
        pop_cnt = '0;
        #1;
        chk("t6_free", free, 4);
        chk("t6_aged_gnt", gnt, 4'b0001);
        step();
        clr_all();
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
